// File: rtl/present_round.sv
// rtl/present_round.sv - one PRESENT-80 round plus round-key update.
// P_ROUND_REG_OUT_EN: registered outputs with sync reset; otherwise combinational.
module present_round (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [0:63] state,
  input  logic [0:79] keys,
  input  logic [4:0]  round_counter,
  output logic [0:63] res,
  output logic [0:79] r_keys
);

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Internal nets use PRESENT LSB numbering; port [0:N] maps positionally.
  logic [63:0] st_l;
  logic [79:0] key_l;
  logic [63:0] add_l;
  logic [63:0] sub_l;
  logic [63:0] perm_l;
  logic [79:0] rot_l;
  logic [79:0] key_next;

  assign st_l  = state;
  assign key_l = keys;
  assign add_l = st_l ^ key_l[79:16];
  assign rot_l = {key_l[18:0], key_l[79:19]};

  always_comb begin
    sub_l  = '0;
    perm_l = '0;
    for (int n = 0; n < 16; n++) begin
      sub_l[n*4 +: 4] = sbox(add_l[n*4 +: 4]);
    end
    for (int i = 0; i < 64; i++) begin
      perm_l[16*(i%4) + i/4] = sub_l[i];
    end
  end

  assign key_next = {sbox(rot_l[79:76]), rot_l[75:20],
                     rot_l[19:15] ^ round_counter, rot_l[14:0]};

`ifdef P_ROUND_REG_OUT_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      res    <= '0;
      r_keys <= '0;
    end else begin
      res    <= perm_l;
      r_keys <= key_next;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = sys_clk ^ sys_rst;
  assign res    = perm_l;
  assign r_keys = key_next;
`endif

endmodule

// File: tb/tb_present_round.sv
// tb/tb_present_round.sv - randomized bench for present_round against a behavioural model.
// Follows P_ROUND_REG_OUT_EN the same way as the design.
module tb_present_round;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [0:63] state;
  logic [0:79] keys;
  logic [4:0]  round_counter;
  logic [0:63] res;
  logic [0:79] r_keys;

  int checks = 0;
  int failures = 0;

  logic [3:0] sbox_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  present_round dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .state        (state),
    .keys         (keys),
    .round_counter(round_counter),
    .res          (res),
    .r_keys       (r_keys)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_res(input logic [63:0] s, input logic [79:0] k);
    logic [63:0] t, u, p;
    t = s ^ k[79:16];
    for (int n = 0; n < 16; n++) u[n*4 +: 4] = sbox_tab[t[n*4 +: 4]];
    p = '0;
    for (int i = 0; i < 63; i++) p[(16*i) % 63] = u[i];
    p[63] = u[63];
    return p;
  endfunction

  function automatic logic [79:0] model_key(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r = (k << 61) | (k >> 19);
    r[79:76] = sbox_tab[r[79:76]];
    r = r ^ ({75'd0, rc} << 15);
    return r;
  endfunction

  task automatic do_round(input logic [63:0] s, input logic [79:0] k, input logic [4:0] rc,
                          output logic [63:0] r, output logic [79:0] rk);
    @(negedge sys_clk);
    state = s;
    keys = k;
    round_counter = rc;
`ifdef P_ROUND_REG_OUT_EN
    @(posedge sys_clk);
    #1;
`else
    #1;
`endif
    r = res;
    rk = r_keys;
  endtask

  task automatic encrypt(input logic [63:0] pt, input logic [79:0] key, output logic [63:0] ct);
    logic [63:0] s;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int rnd = 1; rnd <= 31; rnd++) begin
      do_round(s, k, 5'(rnd), s, k);
    end
    ct = s ^ k[79:16];
  endtask

  initial begin
    logic [63:0] r, ct, s_prev;
    logic [79:0] rk, k_prev;
    logic [4:0]  rc_prev;
    logic [63:0] rs;
    logic [79:0] rkey;
    logic [4:0]  rrc;

    sys_rst = 1'b1;
    state = '0;
    keys = '0;
    round_counter = '0;
`ifdef P_ROUND_REG_OUT_EN
    @(posedge sys_clk);
    #1;
    check("reset_res", {16'd0, res}, 80'd0);
    check("reset_keys", r_keys, 80'd0);
`endif
    @(negedge sys_clk);
    sys_rst = 1'b0;

    do_round(64'd0, 80'd0, 5'd1, r, rk);
    check("zero_res", {16'd0, r}, {16'd0, 64'hFFFFFFFF00000000});
    check("zero_keys", rk, 80'hC0000000000000008000);

    do_round(64'd0, 80'd0, 5'h1F, r, rk);
    check("ctr_1f_keys", rk, 80'hC00000000000000F8000);

    do_round(64'h0123456789ABCDEF, 80'hFFFF0000FFFF0000FFFF, 5'd0, r, rk);
    check("ctr0_res", {16'd0, r}, {16'd0, model_res(64'h0123456789ABCDEF, 80'hFFFF0000FFFF0000FFFF)});
    check("ctr0_keys", rk, model_key(80'hFFFF0000FFFF0000FFFF, 5'd0));

    for (int v = 0; v < 20; v++) begin
      rs = {$urandom, $urandom};
      rkey = {16'($urandom), $urandom, $urandom};
      rrc = 5'($urandom_range(0, 31));
      do_round(rs, rkey, rrc, r, rk);
      check($sformatf("rand_res%0d", v), {16'd0, r}, {16'd0, model_res(rs, rkey)});
      check($sformatf("rand_keys%0d", v), rk, model_key(rkey, rrc));
    end

    encrypt(64'd0, 80'd0, ct);
    check("enc_zero", {16'd0, ct}, {16'd0, 64'h5579C1387B228445});
    encrypt(64'hFFFFFFFFFFFFFFFF, {80{1'b1}}, ct);
    check("enc_ones", {16'd0, ct}, {16'd0, 64'h3333DCD3213210D2});

`ifdef P_ROUND_REG_OUT_EN
    // Reset overrides a nonzero round, then the next edge carries real data.
    @(negedge sys_clk);
    rs = 64'hDEADBEEFCAFEF00D;
    rkey = 80'h123456789ABCDEF01234;
    state = rs;
    keys = rkey;
    round_counter = 5'd7;
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    check("rst_mid_res", {16'd0, res}, 80'd0);
    check("rst_mid_keys", r_keys, 80'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    check("post_rst_res", {16'd0, res}, {16'd0, model_res(rs, rkey)});
    check("post_rst_keys", r_keys, model_key(rkey, 5'd7));

    @(negedge sys_clk);
    s_prev = {$urandom, $urandom};
    k_prev = {16'($urandom), $urandom, $urandom};
    rc_prev = 5'($urandom_range(0, 31));
    state = s_prev;
    keys = k_prev;
    round_counter = rc_prev;
    for (int v = 0; v < 8; v++) begin
      @(posedge sys_clk);
      #1;
      check($sformatf("b2b_res%0d", v), {16'd0, res}, {16'd0, model_res(s_prev, k_prev)});
      check($sformatf("b2b_keys%0d", v), r_keys, model_key(k_prev, rc_prev));
      s_prev = {$urandom, $urandom};
      k_prev = {16'($urandom), $urandom, $urandom};
      rc_prev = 5'($urandom_range(0, 31));
      state = s_prev;
      keys = k_prev;
      round_counter = rc_prev;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
